round_scorer: RTL and testbench
===============================

Name: round_scorer

Overview:
- Sequential producer of the round, win and lose counts that feed the end-of-game detector.
- Accepts one per-round result at a time through a valid/ready handshake and accumulates P1 wins, P1 losses and completed rounds.
- Declares game over on round limit or, optionally, on an unassailable lead, and latches the winner code.
- Sits between the round-judge logic and the game-over/winner display path.

Parameters:
- MAX_ROUNDS, 8, number of completed rounds that ends a game; legal range 1..15.
- EARLY_END, 0, when 1 the game also ends once one side's lead exceeds the remaining rounds.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse: clear counts and begin a new game.
- res_valid  input  1  res_code is valid this cycle.
- res_ready  output  1  block can accept a result this cycle.
- res_code  input  2  result code: 00 draw, 01 P1 wins, 10 P2 wins (P1 loses), 11 illegal.
- round  output  4  completed rounds in the current game.
- win  output  4  rounds won by P1.
- lose  output  4  rounds lost by P1.
- game_over  output  1  high while in the OVER state.
- winner  output  2  result code: 10 P1 ahead, 11 P2 ahead, 01 tie, 00 no result.
- err  output  1  one-cycle pulse when an illegal code is accepted.

Behaviour:
- Reset: rst_n is asynchronous and active-low, one clock domain (clk). While rst_n is low:
  - round, win, lose = 0
  - game_over = 0, winner = 00, err = 0, res_ready = 0
  - state = IDLE
- States:
  - IDLE: res_ready = 0. start → PLAY. All other inputs are ignored.
  - PLAY: res_ready = 1. A transfer occurs when res_valid and res_ready are both high at the rising edge.
  - OVER: res_ready = 0, game_over = 1. start → PLAY. Results are ignored.
- start in any state takes priority:
  - Next state is PLAY.
  - round, win, lose and winner are cleared to 0 and err is deasserted.
  - A res_valid in the same cycle is dropped.
- Effect of an accepted transfer in PLAY:
  - 00: round+1.
  - 01: round+1, win+1.
  - 10: round+1, lose+1.
  - 11: no counter change; err pulses high for exactly the next cycle; state stays PLAY.
- Latency:
  - Counters update on the edge that accepts the transfer and are visible the following cycle.
  - game_over and winner update on that same edge.
- Termination, evaluated on the post-update counts:
  - round == MAX_ROUNDS → OVER.
  - If EARLY_END = 1, also go to OVER when win > lose + (MAX_ROUNDS − round) or lose > win + (MAX_ROUNDS − round).
- Winner latch on entry to OVER:
  - win > lose → 10.
  - lose > win → 11.
  - equal → 01.
  - Holds until start or reset; it is 00 outside OVER.
- Arithmetic:
  - All counts are 4-bit unsigned. Counters never exceed MAX_ROUNDS, so they never wrap.
  - The remaining-rounds subtraction cannot underflow in PLAY because round < MAX_ROUNDS.
- Invariant: win + lose ≤ round at all times.
- Reset mid-game: asynchronous clear to IDLE regardless of any transfer in flight.

Decomposition:
- Shared package game_pkg:
  - result code constants RES_DRAW, RES_P1, RES_P2, RES_BAD.
  - winner code constants WIN_NONE, WIN_TIE, WIN_P1, WIN_P2.
  - state type (IDLE, PLAY, OVER).
  - default MAX_ROUNDS.
- One natural combinational sub-module, lead_check:
  - inputs: post-update win, lose, round, plus MAX_ROUNDS.
  - outputs: limit_hit, early_hit, and the 2-bit winner compare.
- Counters and the FSM stay in round_scorer.

Test Plan:
1. Reset, then start, then 8 results alternating 01/10 with res_valid held high → round = 8, win = 4, lose = 4; game_over rises the cycle after the 8th accept; winner = 01; res_ready = 0 afterward.
2. EARLY_END = 1, start, then five 01 results → after the 5th accept win = 5, lose = 0, round = 5; game_over = 1 and winner = 10, because 5 > 0 + 3.
3. In PLAY, send code 11 followed by 00 → the first produces an err pulse of exactly one cycle with no change to round, win or lose; the second gives round = 1, win = 0, lose = 0.
4. start and res_valid (code 01) asserted in the same cycle after a game with round = 3 → round = 0, win = 0, lose = 0, state PLAY; the result is not counted.
5. Drop rst_n asynchronously between clock edges mid-game (round = 5) → all outputs are 0 immediately and state is IDLE; res_ready stays 0 until start.
6. In OVER, drive res_valid with code 01 for 3 cycles → counts and winner are unchanged; a following start clears winner to 00 and res_ready goes high.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the round scorer and its lead checker.
package game_pkg;

  localparam int unsigned CNT_W          = 4;
  localparam int unsigned MAX_ROUNDS_DEF = 8;

  localparam logic [1:0] RES_DRAW = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_BAD  = 2'b11;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_TIE  = 2'b01;
  localparam logic [1:0] WIN_P1   = 2'b10;
  localparam logic [1:0] WIN_P2   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

endpackage

// File: rtl/lead_check.sv
// Combinational end-of-game test on post-update counts: round limit,
// unassailable lead, and the winner code a game ending now would latch.
module lead_check
  import game_pkg::*;
#(
  parameter int unsigned MAX_ROUNDS = MAX_ROUNDS_DEF
) (
  input  logic [CNT_W-1:0] i_win,
  input  logic [CNT_W-1:0] i_lose,
  input  logic [CNT_W-1:0] i_round,
  output logic             o_limit_hit,
  output logic             o_early_hit,
  output logic [1:0]       o_winner
);

  localparam int unsigned    EXT_W   = CNT_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ROUNDS);

  logic [EXT_W-1:0] w_remain;
  logic [EXT_W-1:0] w_win_ext;
  logic [EXT_W-1:0] w_lose_ext;

  // round never exceeds MAX_CNT, so the remaining count is non-negative
  assign w_remain   = EXT_W'(MAX_CNT - i_round);
  assign w_win_ext  = EXT_W'(i_win);
  assign w_lose_ext = EXT_W'(i_lose);

  assign o_limit_hit = (i_round == MAX_CNT);
  assign o_early_hit = (w_win_ext > (w_lose_ext + w_remain)) ||
                       (w_lose_ext > (w_win_ext + w_remain));

  always_comb begin
    o_winner = WIN_TIE;
    if (i_win > i_lose) begin
      o_winner = WIN_P1;
    end else if (i_lose > i_win) begin
      o_winner = WIN_P2;
    end
  end

endmodule

// File: rtl/round_scorer.sv
// Accumulates per-round results over a valid/ready handshake and declares
// game over on the round limit or, optionally, on an unassailable lead.
module round_scorer
  import game_pkg::*;
#(
  parameter int unsigned MAX_ROUNDS = MAX_ROUNDS_DEF,
  parameter bit          EARLY_END  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [1:0]       res_code,
  output logic [CNT_W-1:0] round,
  output logic [CNT_W-1:0] win,
  output logic [CNT_W-1:0] lose,
  output logic             game_over,
  output logic [1:0]       winner,
  output logic             err
);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_round, r_win, r_lose;
  logic [CNT_W-1:0] w_round_nxt, w_win_nxt, w_lose_nxt;
  logic [CNT_W-1:0] w_round_upd, w_win_upd, w_lose_upd;
  logic [1:0]       r_winner, w_winner_nxt, w_winner_cmp;
  logic             r_err, w_err_nxt;
  logic             r_res_ready, r_game_over;
  logic             w_accept, w_count, w_limit_hit, w_early_hit, w_end;

  // start drops any result presented in the same cycle
  assign w_accept = (r_state == PLAY) && res_valid && !start;
  assign w_count  = w_accept && (res_code != RES_BAD);

  assign w_round_upd = r_round + CNT_W'(w_count);
  assign w_win_upd   = r_win   + CNT_W'(w_count && (res_code == RES_P1));
  assign w_lose_upd  = r_lose  + CNT_W'(w_count && (res_code == RES_P2));

  lead_check #(
    .MAX_ROUNDS (MAX_ROUNDS)
  ) u_lead_check (
    .i_win       (w_win_upd),
    .i_lose      (w_lose_upd),
    .i_round     (w_round_upd),
    .o_limit_hit (w_limit_hit),
    .o_early_hit (w_early_hit),
    .o_winner    (w_winner_cmp)
  );

  assign w_end = w_limit_hit || (EARLY_END && w_early_hit);

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_round_nxt  = r_round;
    w_win_nxt    = r_win;
    w_lose_nxt   = r_lose;
    w_winner_nxt = r_winner;
    w_err_nxt    = 1'b0;
    if (start) begin
      w_state_nxt  = PLAY;
      w_round_nxt  = '0;
      w_win_nxt    = '0;
      w_lose_nxt   = '0;
      w_winner_nxt = WIN_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = IDLE;
        end
        PLAY: begin
          w_round_nxt = w_round_upd;
          w_win_nxt   = w_win_upd;
          w_lose_nxt  = w_lose_upd;
          w_err_nxt   = w_accept && (res_code == RES_BAD);
          if (w_count && w_end) begin
            w_state_nxt  = OVER;
            w_winner_nxt = w_winner_cmp;
          end
        end
        OVER: begin
          w_state_nxt = OVER;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_round     <= '0;
      r_win       <= '0;
      r_lose      <= '0;
      r_winner    <= WIN_NONE;
      r_err       <= 1'b0;
      r_res_ready <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_round     <= w_round_nxt;
      r_win       <= w_win_nxt;
      r_lose      <= w_lose_nxt;
      r_winner    <= w_winner_nxt;
      r_err       <= w_err_nxt;
      r_res_ready <= (w_state_nxt == PLAY);
      r_game_over <= (w_state_nxt == OVER);
    end
  end

  assign res_ready = r_res_ready;
  assign game_over = r_game_over;
  assign round     = r_round;
  assign win       = r_win;
  assign lose      = r_lose;
  assign winner    = r_winner;
  assign err       = r_err;

endmodule

// File: tb/tb_round_scorer.sv
// Bench for round_scorer: a round-limit-only instance and an early-end
// instance share stimulus and are checked against a score-keeping model.
module tb_round_scorer;

  localparam int MAXR = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       res_valid;
  logic [1:0] res_code;

  logic       d0_ready, d1_ready, d0_over, d1_over, d0_err, d1_err;
  logic [3:0] d0_round, d1_round, d0_win, d1_win, d0_lose, d1_lose;
  logic [1:0] d0_winner, d1_winner;

  // {res_ready, round, win, lose, game_over, winner, err}
  logic [1:0][16:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  // score-keeping model, index 0 = round limit only, 1 = early end enabled
  int m_round [2];
  int m_win   [2];
  int m_lose  [2];
  int m_winner[2];
  bit m_play  [2];
  bit m_over  [2];
  bit m_err   [2];

  always #5 clk = ~clk;

  round_scorer #(.MAX_ROUNDS(MAXR), .EARLY_END(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .res_valid(res_valid),
    .res_ready(d0_ready), .res_code(res_code), .round(d0_round),
    .win(d0_win), .lose(d0_lose), .game_over(d0_over),
    .winner(d0_winner), .err(d0_err)
  );

  round_scorer #(.MAX_ROUNDS(MAXR), .EARLY_END(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .res_valid(res_valid),
    .res_ready(d1_ready), .res_code(res_code), .round(d1_round),
    .win(d1_win), .lose(d1_lose), .game_over(d1_over),
    .winner(d1_winner), .err(d1_err)
  );

  assign obs[0] = {d0_ready, d0_round, d0_win, d0_lose, d0_over, d0_winner, d0_err};
  assign obs[1] = {d1_ready, d1_round, d1_win, d1_lose, d1_over, d1_winner, d1_err};

  function automatic logic [16:0] exp_vec(input int k);
    return {m_play[k], 4'(m_round[k]), 4'(m_win[k]), 4'(m_lose[k]),
            m_over[k], 2'(m_winner[k]), m_err[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_round[k] = 0; m_win[k] = 0; m_lose[k] = 0; m_winner[k] = 0;
      m_play[k] = 1'b0; m_over[k] = 1'b0; m_err[k] = 1'b0;
    end
  endtask

  // One clock of game scoring from the rules of play
  task automatic model_step(input bit s, input bit v, input int c);
    int lead;
    int rem;
    for (int k = 0; k < 2; k++) begin
      if (s) begin
        m_round[k] = 0; m_win[k] = 0; m_lose[k] = 0; m_winner[k] = 0;
        m_play[k] = 1'b1; m_over[k] = 1'b0; m_err[k] = 1'b0;
      end else begin
        m_err[k] = 1'b0;
        if (m_play[k] && v) begin
          if (c == 3) begin
            m_err[k] = 1'b1;
          end else begin
            m_round[k] += 1;
            if (c == 1) m_win[k] += 1;
            if (c == 2) m_lose[k] += 1;
            lead = m_win[k] - m_lose[k];
            rem  = MAXR - m_round[k];
            if (m_round[k] == MAXR || (k == 1 && (lead > rem || -lead > rem))) begin
              m_play[k]   = 1'b0;
              m_over[k]   = 1'b1;
              m_winner[k] = (lead > 0) ? 2 : (lead < 0) ? 3 : 1;
            end
          end
        end
      end
    end
  endtask

  // Present inputs, clock once, update the model, settle 1 time unit past the edge
  task automatic tick(input bit s, input bit v, input int c);
    start     = s;
    res_valid = v;
    res_code  = 2'(c);
    @(posedge clk);
    model_step(s, v, c);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (obs[k] !== 17'd0) begin
        n_fail++;
        $display("FAIL reset dut%0d: got %h want %h", k, obs[k], 17'd0);
      end
    end
  endtask

  task automatic test_full_game();
    tick(1'b1, 1'b0, 0);
    for (int i = 0; i < MAXR; i++) begin
      tick(1'b0, 1'b1, (i % 2 == 0) ? 1 : 2);
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (obs[k] !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL full_game dut%0d step %0d: got %h want %h", k, i, obs[k], exp_vec(k));
        end
      end
    end
    n_tests++;
    if (obs[0] !== {1'b0, 4'd8, 4'd4, 4'd4, 1'b1, 2'b01, 1'b0}) begin
      n_fail++;
      $display("FAIL full_game_final: got %h want %h", obs[0],
               {1'b0, 4'd8, 4'd4, 4'd4, 1'b1, 2'b01, 1'b0});
    end
  endtask

  task automatic test_early_end();
    tick(1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1, 1);
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (obs[k] !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL early_end dut%0d step %0d: got %h want %h", k, i, obs[k], exp_vec(k));
        end
      end
    end
    n_tests++;
    if (obs[1] !== {1'b0, 4'd5, 4'd5, 4'd0, 1'b1, 2'b10, 1'b0}) begin
      n_fail++;
      $display("FAIL early_end_over: got %h want %h", obs[1],
               {1'b0, 4'd5, 4'd5, 4'd0, 1'b1, 2'b10, 1'b0});
    end
    n_tests++;
    if (obs[0] !== {1'b1, 4'd5, 4'd5, 4'd0, 1'b0, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL early_end_disabled: got %h want %h", obs[0],
               {1'b1, 4'd5, 4'd5, 4'd0, 1'b0, 2'b00, 1'b0});
    end
  endtask

  task automatic test_illegal_code();
    tick(1'b1, 1'b0, 0);
    tick(1'b0, 1'b1, 3);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (obs[k] !== {1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00, 1'b1}) begin
        n_fail++;
        $display("FAIL illegal_err dut%0d: got %h want %h", k, obs[k],
                 {1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00, 1'b1});
      end
    end
    tick(1'b0, 1'b1, 0);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (obs[k] !== {1'b1, 4'd1, 4'd0, 4'd0, 1'b0, 2'b00, 1'b0}) begin
        n_fail++;
        $display("FAIL illegal_then_draw dut%0d: got %h want %h", k, obs[k],
                 {1'b1, 4'd1, 4'd0, 4'd0, 1'b0, 2'b00, 1'b0});
      end
    end
  endtask

  task automatic test_start_priority();
    tick(1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1);
    tick(1'b1, 1'b1, 1);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (obs[k] !== {1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00, 1'b0} || obs[k] !== exp_vec(k)) begin
        n_fail++;
        $display("FAIL start_priority dut%0d: got %h want %h", k, obs[k],
                 {1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00, 1'b0});
      end
    end
  endtask

  task automatic test_async_reset();
    int codes[5] = '{1, 2, 0, 1, 2};
    tick(1'b1, 1'b0, 0);
    foreach (codes[i]) tick(1'b0, 1'b1, codes[i]);
    n_tests++;
    if (d0_round !== 4'd5) begin
      n_fail++;
      $display("FAIL async_reset_pre: got round %0d want 5", d0_round);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (obs[k] !== 17'd0) begin
        n_fail++;
        $display("FAIL async_reset dut%0d: got %h want %h", k, obs[k], 17'd0);
      end
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b1, 1);
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (obs[k] !== 17'd0) begin
          n_fail++;
          $display("FAIL idle_ignore dut%0d cyc %0d: got %h want %h", k, i, obs[k], 17'd0);
        end
      end
    end
    tick(1'b1, 1'b0, 0);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (obs[k] !== exp_vec(k)) begin
        n_fail++;
        $display("FAIL restart dut%0d: got %h want %h", k, obs[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_over_hold();
    tick(1'b1, 1'b0, 0);
    for (int i = 0; i < MAXR; i++) tick(1'b0, 1'b1, $urandom_range(0, 2));
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1);
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (obs[k] !== exp_vec(k) || !m_over[k]) begin
          n_fail++;
          $display("FAIL over_hold dut%0d cyc %0d: got %h want %h", k, i, obs[k], exp_vec(k));
        end
      end
    end
    tick(1'b1, 1'b0, 0);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (obs[k] !== {1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00, 1'b0}) begin
        n_fail++;
        $display("FAIL over_restart dut%0d: got %h want %h", k, obs[k],
                 {1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00, 1'b0});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (obs[k] !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL random dut%0d cyc %0d: got %h want %h", k, i, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    res_valid = 1'b0;
    res_code  = 2'b00;
    #12;
    test_reset();
    rst_n = 1'b1;
    test_full_game();
    test_early_end();
    test_illegal_code();
    test_start_priority();
    test_async_reset();
    test_over_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
